// File: rtl/cte_rgb2yuv_stream.sv
// RGB->YUV stream converter: input FIFO, one pixel stage, 4:2:2 pair tracker
// and a word serializer emitting U,Y,V(,Y) one component per cycle.
module cte_rgb2yuv_stream #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_en,
    input  logic [3*DW-1:0] rgb_in,
    input  logic            mode_444,
    input  logic            flush,
    output logic            busy,
    output logic            out_valid,
    output logic [DW-1:0]   yuv_out
);
    localparam int W  = DW + 10;
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 3*DW + 3;

    localparam logic signed [W-1:0] CY_R = 77,  CY_G = 150,  CY_B = 29;
    localparam logic signed [W-1:0] CU_R = -43, CU_G = -85,  CU_B = 128;
    localparam logic signed [W-1:0] CV_R = 128, CV_G = -107, CV_B = -21;
    localparam logic signed [W-1:0] RND8 = 128, RND9 = 256;
    localparam logic signed [W-1:0] YMAX = (2**DW) - 1;
    localparam logic signed [W-1:0] CMAX = (2**(DW-1)) - 1;
    localparam logic signed [W-1:0] CMIN = -(2**(DW-1));

    typedef enum logic {CLOSED, OPEN0} pair_t;

    function automatic logic [DW-1:0] sat_y(input logic signed [W-1:0] v);
        if (v < 0)         return '0;
        else if (v > YMAX) return '1;
        else               return v[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] sat_c(input logic signed [W-1:0] v);
        if (v < CMIN)      return {1'b1, {(DW-1){1'b0}}};
        else if (v > CMAX) return {1'b0, {(DW-1){1'b1}}};
        else               return v[DW-1:0];
    endfunction

    // Averaged chroma from two unrounded raw sums; a lone pixel passes itself twice.
    function automatic logic [DW-1:0] chroma2(input logic signed [W-1:0] a,
                                              input logic signed [W-1:0] b);
        logic signed [W-1:0] s;
        s = a + b + RND9;
        return sat_c(s >>> 9);
    endfunction

    // ---------------- input FIFO ----------------
    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   cnt, cnt_nxt;
    logic          wr, pop, pix_take;

    assign wr  = (in_en | flush) & ~busy;
    assign pop = pix_take & (cnt != '0);

    always_comb cnt_nxt = cnt + (AW+1)'(wr) - (AW+1)'(pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else begin
            if (wr)  wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            cnt  <= cnt_nxt;
            busy <= (cnt_nxt == (AW+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= {flush, mode_444, in_en, rgb_in};
    end

    // ---------------- pixel stage ----------------
    logic          pix_vld;
    logic [EW-1:0] pix;
    logic          pix_fl, pix_444, pix_en;
    logic signed [W-1:0] r, g, b, y_raw, u_raw, v_raw, y_rnd, u_rnd, v_rnd;
    logic [DW-1:0] y_now, u_444, v_444;

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_vld <= 1'b0;
            pix     <= '0;
        end else if (pix_take) begin
            pix_vld <= (cnt != '0);
            if (pop) pix <= mem[rptr];
        end
    end

    assign pix_fl  = pix[EW-1];
    assign pix_444 = pix[EW-2];
    assign pix_en  = pix[EW-3];

    always_comb begin
        r     = W'(pix[3*DW-1:2*DW]);
        g     = W'(pix[2*DW-1:DW]);
        b     = W'(pix[DW-1:0]);
        y_raw = CY_R*r + CY_G*g + CY_B*b;
        u_raw = CU_R*r + CU_G*g + CU_B*b;
        v_raw = CV_R*r + CV_G*g + CV_B*b;
        y_rnd = y_raw + RND8;
        u_rnd = u_raw + RND8;
        v_rnd = v_raw + RND8;
        y_now = sat_y(y_rnd >>> 8);
        u_444 = sat_c(u_rnd >>> 8);
        v_444 = sat_c(v_rnd >>> 8);
    end

    // ---------------- pair tracker ----------------
    pair_t               state, nxt;
    logic [DW-1:0]       y0_q;
    logic signed [W-1:0] u0_q, v0_q;
    logic                grp_vld, consume, capture, ser_ready, load;
    logic [1:0]          g_last, rem;
    logic [DW-1:0]       gw [4];
    logic [DW-1:0]       sbuf [3];

    assign ser_ready = (rem == 2'd0);
    assign pix_take  = ~pix_vld | consume;
    assign load      = grp_vld & ser_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLOSED;
            y0_q  <= '0;
            u0_q  <= '0;
            v0_q  <= '0;
        end else begin
            state <= nxt;
            if (capture) begin
                y0_q <= y_now;
                u0_q <= u_raw;
                v0_q <= v_raw;
            end
        end
    end

    // A 444 pixel arriving on an open pair first closes the pair and stays
    // in the pixel stage, so it is converted on the following cycle.
    always_comb begin
        nxt     = state;
        grp_vld = 1'b0;
        g_last  = 2'd2;
        consume = 1'b0;
        capture = 1'b0;
        for (int unsigned i = 0; i < 4; i++) gw[i] = '0;
        if (pix_vld) begin
            unique case (state)
                CLOSED: begin
                    if (!pix_en) begin
                        consume = 1'b1;
                    end else if (pix_444) begin
                        grp_vld = 1'b1;
                        gw[0] = u_444; gw[1] = y_now; gw[2] = v_444;
                        consume = ser_ready;
                    end else if (pix_fl) begin
                        grp_vld = 1'b1;
                        g_last  = 2'd3;
                        gw[0] = chroma2(u_raw, u_raw); gw[1] = y_now;
                        gw[2] = chroma2(v_raw, v_raw); gw[3] = y_now;
                        consume = ser_ready;
                    end else begin
                        capture = 1'b1;
                        consume = 1'b1;
                        nxt     = OPEN0;
                    end
                end
                OPEN0: begin
                    grp_vld = 1'b1;
                    g_last  = 2'd3;
                    if (pix_en && !pix_444) begin
                        gw[0] = chroma2(u0_q, u_raw); gw[1] = y0_q;
                        gw[2] = chroma2(v0_q, v_raw); gw[3] = y_now;
                        consume = ser_ready;
                    end else begin
                        gw[0] = chroma2(u0_q, u0_q); gw[1] = y0_q;
                        gw[2] = chroma2(v0_q, v0_q); gw[3] = y0_q;
                        consume = ser_ready & ~pix_en;
                    end
                    if (ser_ready) nxt = CLOSED;
                end
                default: nxt = CLOSED;
            endcase
        end
    end

    // ---------------- serializer ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            yuv_out   <= '0;
            rem       <= 2'd0;
            for (int unsigned i = 0; i < 3; i++) sbuf[i] <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            yuv_out   <= gw[0];
            sbuf[0]   <= gw[1];
            sbuf[1]   <= gw[2];
            sbuf[2]   <= gw[3];
            rem       <= g_last;
        end else if (rem != 2'd0) begin
            yuv_out <= sbuf[0];
            sbuf[0] <= sbuf[1];
            sbuf[1] <= sbuf[2];
            rem     <= rem - 2'd1;
        end else begin
            out_valid <= 1'b0;
            yuv_out   <= '0;
        end
    end
endmodule
